// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event controller.
//   evt_type_t  : event codes carried on evt_type (PRESS=0, LONG=1, RELEASE=2)
//   btn_state_t : per-button debounce/hold FSM states
//   cnt_width() : width of a saturating counter that must reach max(a, b)
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_RELEASE = 2'd2
  } evt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DB_PRESS = 3'd1,
    ST_PRESSED  = 3'd2,
    ST_HELD     = 3'd3,
    ST_DB_REL   = 3'd4
  } btn_state_t;

  localparam int unsigned N_EVT_TYPES = 3;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/button_fsm.sv
// One button: 2-flop synchronizer, debounce/long-press FSM, ms counter and
// 3-bit pending event mask.
//   clk, rst     : clock, synchronous active-high reset
//   btn_raw      : asynchronous raw button level
//   ms_tick      : one-cycle pulse per millisecond
//   pend_clr     : one-hot clear of pending bits (event taken by output stage)
//   pend         : pending mask, bit0 PRESS, bit1 LONG, bit2 RELEASE
//   level        : debounced button level
//   ovf          : pulse when an event is dropped because its bit was already set
//
// state       | meaning
// ------------+------------------------------------------------------------
// ST_IDLE     | released and stable
// ST_DB_PRESS | high seen, waiting DEBOUNCE_MS of stable high
// ST_PRESSED  | press accepted, timing LONG_MS toward a LONG event
// ST_HELD     | LONG raised, waiting for release
// ST_DB_REL   | low seen while pressed, waiting DEBOUNCE_MS of stable low
module button_fsm
  import btn_evt_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 10,
  parameter int unsigned LONG_MS     = 1000,
  parameter int unsigned CNT_W       = cnt_width(DEBOUNCE_MS, LONG_MS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       ms_tick,
  input  logic [2:0] pend_clr,
  output logic [2:0] pend,
  output logic       level,
  output logic       ovf
);

  localparam logic [CNT_W-1:0] DB_TC   = CNT_W'(DEBOUNCE_MS);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_MS);

  logic [1:0]       sync_q;
  logic             sync;
  btn_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             long_seen, long_d;
  logic [2:0]       evt_set;

  assign sync = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], btn_raw};
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      long_seen <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      long_seen <= long_d;
    end
  end

  // next state; the counter only advances below its terminal value, and a
  // terminal value always causes a transition, so it saturates by design
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    long_d  = long_seen;
    evt_set = 3'b000;
    case (state)
      ST_IDLE: begin
        if (sync) begin
          state_d = ST_DB_PRESS;
          cnt_d   = '0;
          long_d  = 1'b0;
        end
      end
      ST_DB_PRESS: begin
        if (!sync) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt == DB_TC) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
          evt_set = 3'b001;
        end else if (ms_tick) begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!sync) begin
          state_d = ST_DB_REL;
          cnt_d   = '0;
        end else if (cnt == LONG_TC) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
          evt_set = 3'b010;
        end else if (ms_tick) begin
          cnt_d = cnt + 1'b1;
        end
      end
      ST_HELD: begin
        if (!sync) begin
          state_d = ST_DB_REL;
          cnt_d   = '0;
        end
      end
      ST_DB_REL: begin
        if (sync) begin
          // a release bounce resumes the press; the long timer starts over
          state_d = long_seen ? ST_HELD : ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt == DB_TC) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          evt_set = 3'b100;
        end else if (ms_tick) begin
          cnt_d = cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs
  always_comb begin
    level = (state == ST_PRESSED) || (state == ST_HELD) || (state == ST_DB_REL);
  end

  // a new event wins over a same-cycle clear of the same bit
  always_ff @(posedge clk) begin
    if (rst) pend <= 3'b000;
    else     pend <= evt_set | (pend & ~pend_clr);
  end

  assign ovf = |(evt_set & pend & ~pend_clr);

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced multi-button event source with a single-register valid/ready
// output. A shared ms tick drives N_BTN button_fsm instances; a round-robin
// arbiter moves one pending event per cycle into the output register.
//   clk, rst     : clock, synchronous active-high reset
//   btn_in       : raw asynchronous button levels
//   btn_state    : debounced levels
//   evt_valid/evt_ready : event handshake
//   evt_id       : button index of the event
//   evt_type     : PRESS=0, LONG=1, RELEASE=2
//   evt_overflow : sticky flag, an event was dropped
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter  int unsigned CLK_FREQ    = 50000000,
  parameter  int unsigned N_BTN       = 4,
  parameter  int unsigned DEBOUNCE_MS = 10,
  parameter  int unsigned LONG_MS     = 1000,
  localparam int unsigned ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic [1:0]       evt_type,
  output logic             evt_overflow
);

  localparam int unsigned TICK_DIV = (CLK_FREQ / 1000 < 1) ? 1 : CLK_FREQ / 1000;
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              ms_tick;

  logic [2:0]        pend     [N_BTN];
  logic [2:0]        pend_clr [N_BTN];
  logic [N_BTN-1:0]  ovf_vec;

  logic              valid_q;
  logic [ID_W-1:0]   id_q;
  evt_type_t         type_q;
  logic              ovf_q;
  logic [ID_W-1:0]   rr_ptr;

  logic              load;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [2:0]        grant_oh;
  evt_type_t         grant_type;

  assign ms_tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)          tick_cnt <= '0;
    else if (ms_tick) tick_cnt <= '0;
    else              tick_cnt <= tick_cnt + 1'b1;
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    button_fsm #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_btn (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_in[i]),
      .ms_tick  (ms_tick),
      .pend_clr (pend_clr[i]),
      .pend     (pend[i]),
      .level    (btn_state[i]),
      .ovf      (ovf_vec[i])
    );
  end

  assign load = !valid_q || evt_ready;

  // round-robin search starts one past the last granted button
  always_comb begin
    int unsigned idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= N_BTN; k++) begin
      idx = 32'(rr_ptr) + k;
      if (idx >= N_BTN) idx = idx - N_BTN;
      if (!grant_found && (pend[idx] != 3'b000)) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant_oh   = 3'b000;
    grant_type = EVT_PRESS;
    if (pend[grant_idx][0]) begin
      grant_oh   = 3'b001;
      grant_type = EVT_PRESS;
    end else if (pend[grant_idx][1]) begin
      grant_oh   = 3'b010;
      grant_type = EVT_LONG;
    end else if (pend[grant_idx][2]) begin
      grant_oh   = 3'b100;
      grant_type = EVT_RELEASE;
    end
  end

  always_comb begin
    for (int i = 0; i < N_BTN; i++) pend_clr[i] = 3'b000;
    if (load && grant_found) pend_clr[grant_idx] = grant_oh;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      type_q  <= EVT_PRESS;
      rr_ptr  <= '0;
    end else if (load) begin
      valid_q <= grant_found;
      if (grant_found) begin
        id_q   <= grant_idx;
        type_q <= grant_type;
        rr_ptr <= grant_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           ovf_q <= 1'b0;
    else if (|ovf_vec) ovf_q <= 1'b1;
  end

  assign evt_valid    = valid_q;
  assign evt_id       = id_q;
  assign evt_type     = type_q;
  assign evt_overflow = ovf_q;

endmodule
